// File: rtl/bsmodmul_sched_if.sv
`default_nettype none
// ============================================================================
// Module : bsmodmul_sched_if
// Brief  : Requester handshake and bit-serial multiplier signals of bsmodmul_sched
// Rev    : 1.0
// ============================================================================
interface bsmodmul_sched_if #(
  parameter int LEN = 24
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*LEN-1:0] req_a;
  logic [2*LEN-1:0] req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [LEN-1:0]   rsp_q;
  logic             rsp_err;
  logic             mm_a;
  logic [LEN-1:0]   mm_b;
  logic             mm_isync;
  logic             mm_q;
  logic             mm_osync;

  // master: requesters plus multiplier side; slave: the scheduler itself
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mm_q, mm_osync,
    input  req_ready, rsp_valid, rsp_q, rsp_err, mm_a, mm_b, mm_isync
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mm_q, mm_osync,
    output req_ready, rsp_valid, rsp_q, rsp_err, mm_a, mm_b, mm_isync
  );
endinterface
`default_nettype wire

// File: rtl/bsmodmul_sched.sv
`default_nettype none
// ============================================================================
// Module : bsmodmul_sched
// Brief  : Round-robin scheduler sharing one bit-serial modular multiplier
// Rev    : 1.0
// ============================================================================
module bsmodmul_sched #(
  parameter int LEN     = 24,
  parameter int TIMEOUT = 256
) (
  input  wire logic         clk,
  input  wire logic         reset,
  bsmodmul_sched_if.slave   bus
);

  localparam int                c_CW       = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(LEN - 1);
  localparam logic [15:0]       c_T_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic             r_last,      w_last_nxt;
  logic [c_CW-1:0]  r_cnt,       w_cnt_nxt;
  logic [15:0]      r_tcnt,      w_tcnt_nxt;
  logic [LEN-1:0]   r_sh,        w_sh_nxt;
  logic [LEN-1:0]   r_res,       w_res_nxt;
  logic [1:0]       r_req_ready, w_req_ready_nxt;
  logic [1:0]       r_rsp_valid, w_rsp_valid_nxt;
  logic [LEN-1:0]   r_rsp_q,     w_rsp_q_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;
  logic             r_mm_a,      w_mm_a_nxt;
  logic [LEN-1:0]   r_mm_b,      w_mm_b_nxt;
  logic             r_mm_isync,  w_mm_isync_nxt;

  logic             w_gnt;
  logic [LEN-1:0]   w_sel_a;
  logic [LEN-1:0]   w_sel_b;
  logic [1:0]       w_last_oh;
  logic [LEN-1:0]   w_res_shift;

  // On contention the requester that was not served last wins
  assign w_gnt       = (bus.req_valid == 2'b11) ? ~r_last : bus.req_valid[1];
  assign w_sel_a     = w_gnt ? bus.req_a[2*LEN-1:LEN] : bus.req_a[LEN-1:0];
  assign w_sel_b     = w_gnt ? bus.req_b[2*LEN-1:LEN] : bus.req_b[LEN-1:0];
  assign w_last_oh   = r_last ? 2'b10 : 2'b01;
  assign w_res_shift = {bus.mm_q, r_res[LEN-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      r_sh        <= '0;
      r_res       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_q     <= '0;
      r_rsp_err   <= 1'b0;
      r_mm_a      <= 1'b0;
      r_mm_b      <= '0;
      r_mm_isync  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_sh        <= w_sh_nxt;
      r_res       <= w_res_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_q     <= w_rsp_q_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mm_a      <= w_mm_a_nxt;
      r_mm_b      <= w_mm_b_nxt;
      r_mm_isync  <= w_mm_isync_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_tcnt_nxt      = r_tcnt;
    w_sh_nxt        = r_sh;
    w_res_nxt       = r_res;
    w_req_ready_nxt = 2'b00;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_q_nxt     = r_rsp_q;
    w_rsp_err_nxt   = r_rsp_err;
    w_mm_a_nxt      = 1'b0;
    w_mm_b_nxt      = r_mm_b;
    w_mm_isync_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Bit 0 and isync are preloaded so SEND cycle k presents a[k]
        if (|bus.req_valid) begin
          w_state_nxt     = S_SEND;
          w_last_nxt      = w_gnt;
          w_req_ready_nxt = w_gnt ? 2'b10 : 2'b01;
          w_sh_nxt        = w_sel_a >> 1;
          w_mm_a_nxt      = w_sel_a[0];
          w_mm_b_nxt      = w_sel_b;
          w_mm_isync_nxt  = 1'b1;
          w_cnt_nxt       = '0;
        end
      end
      S_SEND: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_WAIT;
          w_tcnt_nxt  = '0;
        end else begin
          w_mm_a_nxt = r_sh[0];
          w_sh_nxt   = r_sh >> 1;
          w_cnt_nxt  = r_cnt + c_CW'(1);
        end
      end
      S_WAIT: begin
        w_tcnt_nxt = r_tcnt + 16'd1;
        if (bus.mm_osync) begin
          w_res_nxt   = {bus.mm_q, {(LEN-1){1'b0}}};
          w_cnt_nxt   = c_CW'(1);
          w_state_nxt = S_RECV;
        end else if (r_tcnt == c_T_LAST) begin
          w_state_nxt     = S_DONE;
          w_rsp_q_nxt     = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = w_last_oh;
        end
      end
      S_RECV: begin
        w_res_nxt = w_res_shift;
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt     = S_DONE;
          w_rsp_q_nxt     = w_res_shift;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = w_last_oh;
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      S_DONE: begin
        if (bus.rsp_ready[r_last]) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 2'b00;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mm_a      = r_mm_a;
  assign bus.mm_b      = r_mm_b;
  assign bus.mm_isync  = r_mm_isync;

endmodule
`default_nettype wire
